// File: rtl/mac_accum_block.sv
// Multiply-accumulate block: sums weight_n weight*activation products, adds a bias and rescales to the shared fixed-point format.
// Optional build macro MAC_ACCUM_SATURATE_EN clamps the result to the output range; otherwise the result wraps.
module mac_accum_block #(
   parameter int weight_n   = 5,
   parameter int data_width = 16,
   parameter int frac_bits  = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [data_width-1:0] weight_in,
   input  logic signed [data_width-1:0] act_in,
   input  logic signed [data_width-1:0] bias_in,
   output logic signed [data_width-1:0] sum_out,
   output logic                         out_valid,
   output logic                         busy
);

   localparam int PROD_W = 2 * data_width;
   localparam int ACC_W  = 2 * data_width + $clog2(weight_n) + 1;
   localparam int SUM_W  = ACC_W + 1;
   localparam int CNT_W  = $clog2(weight_n + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(weight_n);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      FINISH
   } state_t;

   state_t                    state, state_next;
   logic signed [ACC_W-1:0]   acc, acc_next;
   logic        [CNT_W-1:0]   count, count_next, count_inc;
   logic signed [PROD_W-1:0]  product;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [SUM_W-1:0]   bias_scaled, sum_full, r;
   logic        [data_width-1:0] result;

   assign product   = weight_in * act_in;
   assign prod_ext  = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
   assign count_inc = count + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
      end else begin
         state <= state_next;
         acc   <= acc_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next = state;
      acc_next   = acc;
      count_next = count;
      in_ready   = 1'b1;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (in_valid) begin
               acc_next   = prod_ext;
               count_next = CNT_W'(1);
               state_next = (weight_n == 1) ? FINISH : ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               acc_next   = acc + prod_ext;
               count_next = count_inc;
               if (count_inc == LAST_CNT) begin
                  state_next = FINISH;
               end
            end
         end
         FINISH: begin
            in_ready   = 1'b0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Bias is lifted into the product's fixed-point scale before the arithmetic rescale (floor rounding).
   assign bias_scaled = {{(SUM_W-data_width){bias_in[data_width-1]}}, bias_in} <<< frac_bits;
   assign sum_full    = {acc[ACC_W-1], acc} + bias_scaled;
   assign r           = sum_full >>> frac_bits;

`ifdef MAC_ACCUM_SATURATE_EN
   logic in_range;
   assign in_range = (&r[SUM_W-1:data_width-1]) | ~(|r[SUM_W-1:data_width-1]);
   assign result   = in_range ? r[data_width-1:0]
                   : (r[SUM_W-1] ? {1'b1, {(data_width-1){1'b0}}}
                                 : {1'b0, {(data_width-1){1'b1}}});
`else
   logic unused_r_hi;
   assign result      = r[data_width-1:0];
   assign unused_r_hi = ^r[SUM_W-1:data_width];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_out   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state == FINISH);
         if (state == FINISH) begin
            sum_out <= result;
         end
      end
   end

endmodule

// File: tb/tb_mac_accum_block.sv
// Directed bench for mac_accum_block: table of neuron evaluations plus reset-abort and back-to-back sequences.
module tb_mac_accum_block;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] weight_in, act_in, bias_in;
   logic [15:0] sum_out;
   logic        out_valid;
   logic        busy;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   typedef struct {
      logic [15:0] w;
      logic [15:0] a;
      logic [15:0] b;
      int          stall_after;
      int          stall_len;
      logic [15:0] exp_sum;
   } vec_t;

   vec_t vecs[6];

   mac_accum_block #(.weight_n(5), .data_width(16), .frac_bits(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .weight_in (weight_in),
      .act_in    (act_in),
      .bias_in   (bias_in),
      .sum_out   (sum_out),
      .out_valid (out_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Presents five words (with an optional stall) and returns at the negedge of the FINISH cycle.
   task automatic applyStimulus(input vec_t v, input bit hold_valid, output int start_cyc);
      start_cyc = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == v.stall_after) begin
            for (int s = 0; s < v.stall_len; s++) begin
               @(negedge clk);
               checkOutput("busy during stall", {15'd0, busy}, 16'd1);
               in_valid = 1'b0;
            end
         end
         @(negedge clk);
         if (i == 0) start_cyc = cyc;
         in_valid  = 1'b1;
         weight_in = v.w;
         act_in    = v.a;
         bias_in   = v.b;
      end
      @(negedge clk);
      checkOutput("in_ready in FINISH", {15'd0, in_ready}, 16'd0);
      checkOutput("busy in FINISH", {15'd0, busy}, 16'd1);
      if (!hold_valid) in_valid = 1'b0;
   endtask

   task automatic waitResult(input vec_t v, input int start_cyc, input string name);
      int k = 0;
      while (!out_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput({name, " out_valid seen"}, {15'd0, out_valid}, 16'd1);
      if (out_valid) begin
         checkOutput({name, " sum_out"}, sum_out, v.exp_sum);
         checkOutput({name, " latency"}, 16'(cyc - start_cyc), 16'(6 + v.stall_len));
         @(negedge clk);
         checkOutput({name, " single pulse"}, {15'd0, out_valid}, 16'd0);
         checkOutput({name, " sum_out held"}, sum_out, v.exp_sum);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int st;
      int pulses, ready_low, p1, p2, c0;
      logic [15:0] s1, s2;

      vecs[0] = '{16'h0100, 16'h0200, 16'h0080, -1, 0, 16'h0A80};
      vecs[1] = '{16'hFF00, 16'h0300, 16'h0000, -1, 0, 16'hF100};
`ifdef MAC_ACCUM_SATURATE_EN
      vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, -1, 0, 16'h7FFF};
      vecs[3] = '{16'h8000, 16'h7FFF, 16'h0000, -1, 0, 16'h8000};
`else
      vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, -1, 0, 16'hFB00};
      vecs[3] = '{16'h8000, 16'h7FFF, 16'h0000, -1, 0, 16'h0280};
`endif
      vecs[4] = '{16'h0001, 16'h0001, 16'hFFFF, -1, 0, 16'hFFFF};
      vecs[5] = '{16'h0100, 16'h0200, 16'h0080, 2, 3, 16'h0A80};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      weight_in = '0;
      act_in    = '0;
      bias_in   = '0;
      #3;
      checkOutput("reset sum_out", sum_out, 16'h0000);
      checkOutput("reset out_valid", {15'd0, out_valid}, 16'd0);
      checkOutput("reset busy", {15'd0, busy}, 16'd0);
      checkOutput("reset in_ready", {15'd0, in_ready}, 16'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i], 1'b0, st);
         waitResult(vecs[i], st, $sformatf("vec%0d", i));
      end

      // Reset during accumulation: partial sum must be discarded.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid  = 1'b1;
         weight_in = 16'h0100;
         act_in    = 16'h0200;
         bias_in   = 16'h0080;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("abort busy before reset", {15'd0, busy}, 16'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort busy", {15'd0, busy}, 16'd0);
      checkOutput("abort in_ready", {15'd0, in_ready}, 16'd1);
      checkOutput("abort sum_out", sum_out, 16'h0000);
      @(negedge clk);
      rst_n  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      checkOutput("abort no pulse", 16'(pulses), 16'd0);
      applyStimulus(vecs[1], 1'b0, st);
      waitResult(vecs[1], st, "after abort");

      // Back-to-back evaluations with in_valid held high throughout.
      @(negedge clk);
      c0        = cyc;
      in_valid  = 1'b1;
      weight_in = 16'h0100;
      act_in    = 16'h0200;
      bias_in   = 16'h0080;
      pulses    = 0;
      ready_low = 0;
      p1 = 0; p2 = 0; s1 = '0; s2 = '0;
      for (int i = 0; i < 30 && pulses < 2; i++) begin
         @(negedge clk);
         if (!in_ready) ready_low++;
         if (out_valid) begin
            pulses++;
            if (pulses == 1) begin
               p1 = cyc;
               s1 = sum_out;
            end else begin
               p2 = cyc;
               s2 = sum_out;
               in_valid = 1'b0;
            end
         end
      end
      checkOutput("b2b pulse count", 16'(pulses), 16'd2);
      checkOutput("b2b first latency", 16'(p1 - c0), 16'd6);
      checkOutput("b2b spacing", 16'(p2 - p1), 16'd6);
      checkOutput("b2b sum 1", s1, 16'h0A80);
      checkOutput("b2b sum 2", s2, 16'h0A80);
      checkOutput("b2b in_ready low cycles", 16'(ready_low), 16'd2);
      @(negedge clk);
      checkOutput("b2b idle after", {15'd0, busy}, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
